seq_restoring_divider: RTL and testbench

- Parametrised, multi-cycle successor to the combinational restoring-divider array.
- Computes one quotient bit per clock using a single shared (DW+1)-bit subtract/restore stage, iterating QW times instead of instantiating QW rows.
- Adds valid/ready handshakes on both sides, divide-by-zero and quotient-overflow detection, and output hold under backpressure.
- Sits between operand producers and result consumers in divider benchmark datapaths.

---
 rtl/seq_restoring_divider.sv | 152 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock through a single
// shared subtract/restore stage, with valid/ready handshakes on both sides.
module seq_restoring_divider #(
  parameter  int DW = 3,
  parameter  int QW = 4,
  localparam int RW = QW + DW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rin,
  input  logic [DW-1:0] div,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q,
  output logic [DW:0]   rout,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_p;
  logic [QW-1:0] r_s;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_q;
  logic [DW:0]   r_rout;
  logic          r_dz;
  logic          r_ovf;

  logic          w_dz;
  logic          w_ovf;
  logic          w_last;
  logic [DW:0]   w_w;
  logic [DW+1:0] w_d;
  logic          w_qbit;
  logic [DW:0]   w_rem;

  assign w_dz   = (div == {DW{1'b0}});
  assign w_ovf  = ({1'b0, rin[RW-1:QW]} >= div);
  assign w_last = (r_cnt == {CW{1'b0}});

  // One row of the array divider: trial subtract, keep or restore.
  assign w_w    = {r_p, r_s[QW-1]};
  assign w_d    = {1'b0, w_w} - {2'b00, r_div};
  assign w_qbit = ~w_d[DW+1];
  assign w_rem  = w_qbit ? w_d[DW:0] : w_w;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_dz || w_ovf) w_next = S_DONE;
          else               w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Operand load, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= {DW{1'b0}};
      r_p    <= {DW{1'b0}};
      r_s    <= {QW{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_q    <= {QW{1'b0}};
      r_rout <= {(DW+1){1'b0}};
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div <= div;
            if (w_dz || w_ovf) begin
              r_dz   <= w_dz;
              r_ovf  <= ~w_dz;
              r_q    <= {QW{1'b1}};
              r_rout <= {(DW+1){1'b0}};
            end else begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b0;
              r_q   <= {QW{1'b0}};
              r_p   <= {1'b0, rin[RW-1:QW]};
              r_s   <= rin[QW-1:0];
              r_cnt <= CW'(QW - 1);
            end
          end
        end
        S_RUN: begin
          // Quotient bits arrive MSB first, so shifting in lands them at q[cnt].
          r_q   <= {r_q[QW-2:0], w_qbit};
          r_p   <= w_rem[DW-1:0];
          r_s   <= {r_s[QW-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          // Remainder is below the divisor, so w_rem's MSB is already zero.
          if (w_last) r_rout <= w_rem;
        end
        default: begin
          r_div <= r_div;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign rout      = r_rout;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed checks of the default divider plus a reference-model sweep
// of a DW=4, QW=6 instance.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, dz, ovf;
  logic [5:0] rin;
  logic [2:0] div;
  logic [3:0] q;
  logic [3:0] rout;

  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, dz_b, ovf_b;
  logic [8:0] rin_b;
  logic [3:0] div_b;
  logic [5:0] q_b;
  logic [4:0] rout_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rin(rin), .div(div), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .rout(rout), .dz(dz), .ovf(ovf)
  );

  seq_restoring_divider #(.DW(4), .QW(6)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .rin(rin_b), .div(div_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .q(q_b), .rout(rout_b), .dz(dz_b), .ovf(ovf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called #1 after the accept edge; lat counts edges from accept to out_valid.
  task automatic wait_done_a(output int lat, output int low);
    lat = 1;
    low = in_ready ? 0 : 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) low++;
    end
  endtask

  task automatic run_a(input string tag, input int a, input int b, input int eq, input int er,
                       input int edz, input int eovf, input int elat);
    int lat, low;
    @(negedge clk);
    rin = 6'(a); div = 3'(b); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done_a(lat, low);
    check_eq({tag, "_lat"}, lat, elat);
    check_eq({tag, "_q"}, q, eq);
    check_eq({tag, "_rout"}, rout, er);
    check_eq({tag, "_dz"}, dz, edz);
    check_eq({tag, "_ovf"}, ovf, eovf);
    check_eq({tag, "_rdy_in_done"}, in_ready, 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_rdy_back"}, in_ready, 1);
    check_eq({tag, "_rdy_low_cycles"}, low, elat);
  endtask

  task automatic run_b(input int a, input int b);
    int lat, eq, er, edz, eovf, elat;
    if (b == 0) begin
      eq = 63; er = 0; edz = 1; eovf = 0; elat = 1;
    end else if ((a >> 6) >= b) begin
      eq = 63; er = 0; edz = 0; eovf = 1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 0; eovf = 0; elat = 7;
    end
    @(negedge clk);
    rin_b = 9'(a); div_b = 4'(b); in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    lat = 1;
    while (!out_valid_b && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("b_lat", lat, elat);
    check_eq("b_q", q_b, eq);
    check_eq("b_rout", rout_b, er);
    check_eq("b_dz", dz_b, edz);
    check_eq("b_ovf", ovf_b, eovf);
    @(posedge clk); #1;
    check_eq("b_rdy_back", in_ready_b, 1);
  endtask

  initial begin
    int lat, low;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; rin = 6'd0; div = 3'd0;
    in_valid_b = 1'b0; out_ready_b = 1'b1; rin_b = 9'd0; div_b = 4'd0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_q", q, 0);
    check_eq("rst_rout", rout, 0);
    check_eq("rst_dz", dz, 0);
    check_eq("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;

    run_a("d45_6", 45, 6, 7, 3, 0, 0, 5);
    run_a("d5_7", 5, 7, 0, 5, 0, 0, 5);
    run_a("d0_1", 0, 1, 0, 0, 0, 0, 5);
    run_a("d15_1", 15, 1, 15, 0, 0, 0, 5);
    run_a("dz20", 20, 0, 15, 0, 1, 0, 1);
    run_a("ovf63_3", 63, 3, 15, 0, 0, 1, 1);
    run_a("ovf32_2", 32, 2, 15, 0, 0, 1, 1);
    run_a("d31_2", 31, 2, 15, 1, 0, 0, 5);

    // Backpressure: hold DONE for 3 edges while a new operand waits.
    @(negedge clk);
    rin = 6'd45; div = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done_a(lat, low);
    check_eq("bp_lat", lat, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rin = 6'd5; div = 3'd7; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_ready", in_ready, 0);
      check_eq("bp_hold_q", q, 7);
      check_eq("bp_hold_rout", rout, 3);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_valid", out_valid, 0);
    check_eq("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check_eq("bp_next_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_done_a(lat, low);
    check_eq("bp_next_lat", lat, 5);
    check_eq("bp_next_q", q, 0);
    check_eq("bp_next_rout", rout, 5);
    @(posedge clk); #1;
    check_eq("bp_idle", in_ready, 1);

    // Reset two edges into RUN aborts the operation immediately.
    @(negedge clk);
    rin = 6'd45; div = 3'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("ar_in_ready", in_ready, 1);
    check_eq("ar_out_valid", out_valid, 0);
    check_eq("ar_q", q, 0);
    check_eq("ar_rout", rout, 0);
    check_eq("ar_dz", dz, 0);
    check_eq("ar_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ar_no_result", out_valid, 0);
    run_a("d44_5", 44, 5, 8, 4, 0, 0, 5);

    // Wider instance against an arithmetic reference.
    run_b(511, 15);
    run_b(100, 0);
    run_b(64, 1);
    run_b(63, 1);
    for (int i = 0; i < 400; i++) begin
      run_b(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
